// File: rtl/lca_data_bus_router_if.sv
// Core-side OBI-style data bus of the LCA router.
// Signal suffixes are relative to the router: _i are driven by the core, _o by the router.
interface lca_data_bus_router_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/lca_data_bus_router.sv
// Routes the core data port to N_TGT targets, a 16-byte MMIO block or a decode-error responder,
// keeping responses in order by only granting to the destination that already has transactions in flight.
module lca_data_bus_router #(
  parameter int unsigned              N_TGT       = 4,
  parameter int unsigned              MAX_OUT     = 2,
  parameter logic [N_TGT-1:0][31:0]   REGION_BASE = {N_TGT{32'h0}},
  parameter logic [N_TGT-1:0][31:0]   REGION_SIZE = {N_TGT{32'h30000}},
  parameter logic [31:0]              MMIO_BASE   = 32'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lca_data_bus_router_if.slave  core,
  output logic [N_TGT-1:0]      tgt_req_o,
  input  logic [N_TGT-1:0]      tgt_gnt_i,
  output logic [31:0]           tgt_addr_o,
  output logic                  tgt_wen_o,
  output logic [3:0]            tgt_be_o,
  output logic [31:0]           tgt_wdata_o,
  input  logic [N_TGT-1:0]      tgt_rvalid_i,
  input  logic [N_TGT*32-1:0]   tgt_rdata_i,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_code_o,
  output logic                  print_valid_o,
  output logic [7:0]            print_char_o
);

  localparam int unsigned      DST_W    = $clog2(N_TGT + 2);
  localparam int unsigned      CNT_W    = $clog2(MAX_OUT + 1);
  localparam logic [DST_W-1:0] DST_MMIO = DST_W'(N_TGT);
  localparam logic [DST_W-1:0] DST_ERR  = DST_W'(N_TGT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

  logic [N_TGT-1:0][31:0] region_base, region_size;
  logic [31:0]            mmio_base;
  logic [32:0]            mmio_off;
  logic [32:0]            region_off;
  logic                   mmio_hit;
  logic [DST_W-1:0]       dst;
  logic                   is_local;
  logic                   stall;
  logic                   accept;
  logic                   local_acc;
  logic                   mmio_wr;
  logic [31:0]            lrsp_rdata_d;
  logic                   tgt_rsp_valid;
  logic [31:0]            tgt_rsp_data;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [DST_W-1:0]       last_dst_q;
  logic [31:0]            cycle_cnt_q;
  logic                   lrsp_valid_q, lrsp_err_q;
  logic [31:0]            lrsp_rdata_q;
  logic                   exit_valid_q, print_valid_q;
  logic [31:0]            exit_code_q;
  logic [7:0]             print_char_q;

  assign region_base = REGION_BASE;
  assign region_size = REGION_SIZE;
  assign mmio_base   = MMIO_BASE;

  // An offset computed in 33 bits has bit 32 set when addr is below the base, so one compare covers both bounds.
  assign mmio_off = {1'b0, core.addr_i} - {1'b0, mmio_base};
  assign mmio_hit = mmio_off < 33'd16;

  always_comb begin
    dst        = DST_ERR;
    region_off = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      region_off = {1'b0, core.addr_i} - {1'b0, region_base[i]};
      if (region_off < {1'b0, region_size[i]}) dst = DST_W'(i);
    end
    if (mmio_hit) dst = DST_MMIO;
  end

  assign is_local = (dst == DST_MMIO) || (dst == DST_ERR);
  assign stall    = (cnt_q == CNT_MAX) || ((cnt_q != '0) && (dst != last_dst_q));

  always_comb begin
    tgt_req_o  = '0;
    core.gnt_o = 1'b0;
    if (core.req_i && !stall) begin
      if (is_local) begin
        core.gnt_o = 1'b1;
      end else begin
        for (int i = 0; i < N_TGT; i++) begin
          if (dst == DST_W'(i)) begin
            tgt_req_o[i] = 1'b1;
            core.gnt_o   = tgt_gnt_i[i];
          end
        end
      end
    end
  end

  assign tgt_addr_o  = core.addr_i;
  assign tgt_wen_o   = ~core.we_i;
  assign tgt_be_o    = core.be_i;
  assign tgt_wdata_o = core.wdata_i;

  assign accept    = core.req_i && core.gnt_o;
  assign local_acc = accept && is_local;
  assign mmio_wr   = accept && (dst == DST_MMIO) && core.we_i;

  always_comb begin
    lrsp_rdata_d = '0;
    if ((dst == DST_MMIO) && !core.we_i && !core.addr_i[2]) lrsp_rdata_d = cycle_cnt_q;
  end

  // Only the destination recorded in last_dst may answer, and only while something is outstanding.
  always_comb begin
    tgt_rsp_valid = 1'b0;
    tgt_rsp_data  = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if ((last_dst_q == DST_W'(i)) && (cnt_q != '0)) begin
        tgt_rsp_valid = tgt_rvalid_i[i];
        tgt_rsp_data  = tgt_rdata_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    core.rvalid_o = lrsp_valid_q || tgt_rsp_valid;
    core.err_o    = lrsp_valid_q && lrsp_err_q;
    core.rdata_o  = '0;
    if (lrsp_valid_q)       core.rdata_o = lrsp_rdata_q;
    else if (tgt_rsp_valid) core.rdata_o = tgt_rsp_data;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !core.rvalid_o)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && core.rvalid_o) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      last_dst_q    <= DST_ERR;
      cycle_cnt_q   <= '0;
      lrsp_valid_q  <= 1'b0;
      lrsp_err_q    <= 1'b0;
      lrsp_rdata_q  <= '0;
      exit_valid_q  <= 1'b0;
      exit_code_q   <= '0;
      print_valid_q <= 1'b0;
      print_char_q  <= '0;
    end else begin
      cnt_q         <= cnt_d;
      cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      if (accept) last_dst_q <= dst;
      lrsp_valid_q  <= local_acc;
      lrsp_err_q    <= local_acc && (dst == DST_ERR);
      lrsp_rdata_q  <= local_acc ? lrsp_rdata_d : 32'd0;
      exit_valid_q  <= mmio_wr && (core.addr_i[3:2] == 2'd0);
      print_valid_q <= mmio_wr && (core.addr_i[3:2] == 2'd1);
      if (mmio_wr && (core.addr_i[3:2] == 2'd0)) exit_code_q  <= core.wdata_i;
      if (mmio_wr && (core.addr_i[3:2] == 2'd1)) print_char_q <= core.wdata_i[7:0];
    end
  end

  assign exit_valid_o  = exit_valid_q;
  assign exit_code_o   = exit_code_q;
  assign print_valid_o = print_valid_q;
  assign print_char_o  = print_char_q;

  // A target answering out of turn would break response ordering.
  for (genvar g = 0; g < N_TGT; g++) begin : g_rsp_chk
    a_rsp_in_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tgt_rvalid_i[g] |-> ((cnt_q != '0) && (last_dst_q == DST_W'(g))));
  end

endmodule

// File: tb/tb_lca_data_bus_router.sv
// Directed bench for lca_data_bus_router with four distinct target regions, one overlapping and one disabled.
module tb_lca_data_bus_router;
  localparam int          N_TGT = 4;
  localparam logic [31:0] MMIO  = 32'h8000_0000;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [N_TGT-1:0]    tgt_req_o, tgt_gnt_i, tgt_rvalid_i;
  logic [31:0]         tgt_addr_o, tgt_wdata_o, exit_code_o;
  logic                tgt_wen_o, exit_valid_o, print_valid_o;
  logic [3:0]          tgt_be_o;
  logic [N_TGT*32-1:0] tgt_rdata_i;
  logic [7:0]          print_char_o;
  int                  nChecks = 0;
  int                  nFails = 0;

  always #5 clk_i = ~clk_i;

  lca_data_bus_router_if bus();

  // Region 1 is widened to overlap the start of region 2; region 3 is disabled with size 0.
  lca_data_bus_router #(
    .N_TGT(N_TGT), .MAX_OUT(2),
    .REGION_BASE({32'h1009_0000, 32'h1006_0000, 32'h1003_0000, 32'h1000_0000}),
    .REGION_SIZE({32'h0000_0000, 32'h0003_0000, 32'h0004_0000, 32'h0003_0000}),
    .MMIO_BASE(MMIO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core(bus),
    .tgt_req_o(tgt_req_o), .tgt_gnt_i(tgt_gnt_i), .tgt_addr_o(tgt_addr_o),
    .tgt_wen_o(tgt_wen_o), .tgt_be_o(tgt_be_o), .tgt_wdata_o(tgt_wdata_o),
    .tgt_rvalid_i(tgt_rvalid_i), .tgt_rdata_i(tgt_rdata_i),
    .exit_valid_o(exit_valid_o), .exit_code_o(exit_code_o),
    .print_valid_o(print_valid_o), .print_char_o(print_char_o)
  );

  task test_reset;
    @(negedge clk_i); @(negedge clk_i);
    #1;
    nChecks++; if (bus.gnt_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_gnt: got %b expected 0", bus.gnt_o); end
    nChecks++; if (bus.rvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_rvalid: got %b expected 0", bus.rvalid_o); end
    nChecks++; if (bus.rdata_o !== 32'h0) begin nFails++; $display("[TB] FAIL rst_rdata: got %h expected 0", bus.rdata_o); end
    nChecks++; if (bus.err_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_err: got %b expected 0", bus.err_o); end
    nChecks++; if (tgt_req_o !== 4'b0) begin nFails++; $display("[TB] FAIL rst_tgt_req: got %b expected 0", tgt_req_o); end
    nChecks++; if (exit_valid_o !== 1'b0 || print_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_pulses: got %b%b expected 00", exit_valid_o, print_valid_o); end
    nChecks++; if (exit_code_o !== 32'h0 || print_char_o !== 8'h0) begin nFails++; $display("[TB] FAIL rst_mmio_regs: got %h/%h expected 0/0", exit_code_o, print_char_o); end
    nChecks++; if (dut.cnt_q !== '0) begin nFails++; $display("[TB] FAIL rst_cnt: got %0d expected 0", dut.cnt_q); end
    nChecks++; if (dut.cycle_cnt_q !== 32'h0) begin nFails++; $display("[TB] FAIL rst_cycle_cnt: got %h expected 0", dut.cycle_cnt_q); end
    rst_ni = 1'b1;
  endtask

  task test_target_read;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h1003_0004; tgt_gnt_i = 4'b0010;
    #1;
    nChecks++; if (tgt_req_o !== 4'b0010) begin nFails++; $display("[TB] FAIL rd_tgt_req: got %b expected 0010", tgt_req_o); end
    nChecks++; if (bus.gnt_o !== 1'b1) begin nFails++; $display("[TB] FAIL rd_gnt: got %b expected 1", bus.gnt_o); end
    nChecks++; if (tgt_addr_o !== 32'h1003_0004 || tgt_wen_o !== 1'b1) begin nFails++; $display("[TB] FAIL rd_shared: got %h/%b expected 10030004/1", tgt_addr_o, tgt_wen_o); end
    @(negedge clk_i);
    bus.req_i = 1'b0; tgt_gnt_i = 4'b0;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL rd_early_rvalid: got %b expected 0", bus.rvalid_o); end
    @(negedge clk_i);
    tgt_rvalid_i = 4'b0010; tgt_rdata_i[63:32] = 32'hDEAD_BEEF;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.err_o !== 1'b0) begin nFails++; $display("[TB] FAIL rd_rvalid: got %b/%b expected 1/0", bus.rvalid_o, bus.err_o); end
    nChecks++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL rd_rdata: got %h expected deadbeef", bus.rdata_o); end
    @(negedge clk_i);
    tgt_rvalid_i = 4'b0;
    #1;
    nChecks++; if (dut.cnt_q !== '0) begin nFails++; $display("[TB] FAIL rd_cnt: got %0d expected 0", dut.cnt_q); end
  endtask

  task test_mmio_exit;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = MMIO; bus.wdata_i = 32'h0;
    #1;
    nChecks++; if (bus.gnt_o !== 1'b1 || tgt_req_o !== 4'b0) begin nFails++; $display("[TB] FAIL exit_gnt: got %b/%b expected 1/0000", bus.gnt_o, tgt_req_o); end
    nChecks++; if (tgt_wen_o !== 1'b0) begin nFails++; $display("[TB] FAIL exit_wen: got %b expected 0", tgt_wen_o); end
    @(negedge clk_i);
    bus.req_i = 1'b0; bus.we_i = 1'b0;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.err_o !== 1'b0) begin nFails++; $display("[TB] FAIL exit_rvalid: got %b/%b expected 1/0", bus.rvalid_o, bus.err_o); end
    nChecks++; if (exit_valid_o !== 1'b1 || exit_code_o !== 32'h0) begin nFails++; $display("[TB] FAIL exit_pulse: got %b/%h expected 1/0", exit_valid_o, exit_code_o); end
    @(negedge clk_i);
    #1;
    nChecks++; if (exit_valid_o !== 1'b0 || bus.rvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL exit_one_shot: got %b/%b expected 0/0", exit_valid_o, bus.rvalid_o); end
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.wdata_i = 32'hCAFE_0001;
    @(negedge clk_i);
    bus.req_i = 1'b0; bus.we_i = 1'b0;
    #1;
    nChecks++; if (exit_valid_o !== 1'b1 || exit_code_o !== 32'hCAFE_0001) begin nFails++; $display("[TB] FAIL exit_code: got %b/%h expected 1/cafe0001", exit_valid_o, exit_code_o); end
  endtask

  task test_print;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = MMIO + 32'h4; bus.wdata_i = 32'h0000_0141; bus.be_i = 4'b0001;
    @(negedge clk_i);
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'hF;
    #1;
    nChecks++; if (print_valid_o !== 1'b1 || print_char_o !== 8'h41) begin nFails++; $display("[TB] FAIL print_pulse: got %b/%h expected 1/41", print_valid_o, print_char_o); end
    nChecks++; if (exit_valid_o !== 1'b0 || exit_code_o !== 32'hCAFE_0001) begin nFails++; $display("[TB] FAIL print_no_exit: got %b/%h expected 0/cafe0001", exit_valid_o, exit_code_o); end
    @(negedge clk_i);
    #1;
    nChecks++; if (print_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL print_one_shot: got %b expected 0", print_valid_o); end
  endtask

  task test_decode_error;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_0010;
    #1;
    nChecks++; if (bus.gnt_o !== 1'b1 || tgt_req_o !== 4'b0) begin nFails++; $display("[TB] FAIL err_gnt: got %b/%b expected 1/0000", bus.gnt_o, tgt_req_o); end
    @(negedge clk_i);
    bus.req_i = 1'b0;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.err_o !== 1'b1 || bus.rdata_o !== 32'h0) begin nFails++; $display("[TB] FAIL err_rsp: got %b/%b/%h expected 1/1/0", bus.rvalid_o, bus.err_o, bus.rdata_o); end
  endtask

  task test_decode_map;
    logic [31:0] addrs [9];
    logic [3:0]  reqs  [9];
    addrs = '{32'h1000_0000, 32'h1002_FFFC, 32'h1003_0000, 32'h1006_0000, 32'h1007_0000,
              32'h1008_FFFC, 32'h1009_0000, 32'h0FFF_FFFC, 32'h8000_0010};
    reqs  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    tgt_gnt_i = 4'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = addrs[i];
      #1;
      nChecks++; if (tgt_req_o !== reqs[i]) begin nFails++; $display("[TB] FAIL map_%0d: addr %h got %b expected %b", i, addrs[i], tgt_req_o, reqs[i]); end
      #1 bus.req_i = 1'b0;
    end
  endtask

  task test_outstanding;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h1000_0000; tgt_gnt_i = 4'b0001;
    #1;
    nChecks++; if (bus.gnt_o !== 1'b1) begin nFails++; $display("[TB] FAIL out_gnt1: got %b expected 1", bus.gnt_o); end
    @(negedge clk_i); #1;
    nChecks++; if (bus.gnt_o !== 1'b1) begin nFails++; $display("[TB] FAIL out_gnt2: got %b expected 1", bus.gnt_o); end
    @(negedge clk_i); #1;
    nChecks++; if (bus.gnt_o !== 1'b0 || tgt_req_o !== 4'b0) begin nFails++; $display("[TB] FAIL out_stall_max: got %b/%b expected 0/0000", bus.gnt_o, tgt_req_o); end
    tgt_rvalid_i = 4'b0001; tgt_rdata_i[31:0] = 32'h0000_0011;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h11 || bus.gnt_o !== 1'b0) begin nFails++; $display("[TB] FAIL out_rsp1: got %b/%h/%b expected 1/11/0", bus.rvalid_o, bus.rdata_o, bus.gnt_o); end
    @(negedge clk_i);
    tgt_rvalid_i = 4'b0;
    #1;
    nChecks++; if (bus.gnt_o !== 1'b1 || dut.cnt_q !== 2'd1) begin nFails++; $display("[TB] FAIL out_gnt3: got %b/%0d expected 1/1", bus.gnt_o, dut.cnt_q); end
    @(negedge clk_i);
    bus.addr_i = 32'h1007_0000; tgt_gnt_i = 4'b0100;
    #1;
    nChecks++; if (bus.gnt_o !== 1'b0 || tgt_req_o !== 4'b0) begin nFails++; $display("[TB] FAIL out_t2_stall_a: got %b/%b expected 0/0000", bus.gnt_o, tgt_req_o); end
    tgt_rvalid_i = 4'b0001; tgt_rdata_i[31:0] = 32'h0000_0022;
    @(negedge clk_i); #1;
    nChecks++; if (bus.gnt_o !== 1'b0 || dut.cnt_q !== 2'd1) begin nFails++; $display("[TB] FAIL out_t2_stall_b: got %b/%0d expected 0/1", bus.gnt_o, dut.cnt_q); end
    @(negedge clk_i);
    tgt_rvalid_i = 4'b0;
    #1;
    nChecks++; if (bus.gnt_o !== 1'b1 || tgt_req_o !== 4'b0100) begin nFails++; $display("[TB] FAIL out_t2_gnt: got %b/%b expected 1/0100", bus.gnt_o, tgt_req_o); end
    @(negedge clk_i);
    bus.req_i = 1'b0; tgt_gnt_i = 4'b0; tgt_rvalid_i = 4'b0100; tgt_rdata_i[95:64] = 32'h0000_0033;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h33) begin nFails++; $display("[TB] FAIL out_t2_rsp: got %b/%h expected 1/33", bus.rvalid_o, bus.rdata_o); end
    @(negedge clk_i);
    tgt_rvalid_i = 4'b0;
    #1;
    nChecks++; if (dut.cnt_q !== '0) begin nFails++; $display("[TB] FAIL out_drain: got %0d expected 0", dut.cnt_q); end
  endtask

  task test_cycle_wrap;
    @(negedge clk_i);
    dut.cycle_cnt_q = 32'hFFFF_FFFF;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = MMIO + 32'h8;
    @(negedge clk_i); #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL cyc_max: got %b/%h expected 1/ffffffff", bus.rvalid_o, bus.rdata_o); end
    nChecks++; if (bus.gnt_o !== 1'b1) begin nFails++; $display("[TB] FAIL cyc_b2b_gnt: got %b expected 1", bus.gnt_o); end
    @(negedge clk_i);
    bus.req_i = 1'b0;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h0) begin nFails++; $display("[TB] FAIL cyc_wrap: got %b/%h expected 1/0", bus.rvalid_o, bus.rdata_o); end
  endtask

  task test_reset_mid;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h1000_0100; tgt_gnt_i = 4'b0001;
    @(negedge clk_i);
    bus.req_i = 1'b0; tgt_gnt_i = 4'b0;
    #1;
    nChecks++; if (dut.cnt_q !== 2'd1) begin nFails++; $display("[TB] FAIL mid_cnt_before: got %0d expected 1", dut.cnt_q); end
    rst_ni = 1'b0;
    #1;
    tgt_rvalid_i = 4'b0001; tgt_rdata_i[31:0] = 32'h0000_0055;
    #1;
    nChecks++; if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 32'h0) begin nFails++; $display("[TB] FAIL mid_late_rsp: got %b/%h expected 0/0", bus.rvalid_o, bus.rdata_o); end
    @(negedge clk_i);
    tgt_rvalid_i = 4'b0;
    rst_ni = 1'b1;
    #1;
    nChecks++; if (dut.cnt_q !== '0 || bus.rvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL mid_after: got %0d/%b expected 0/0", dut.cnt_q, bus.rvalid_o); end
    nChecks++; if (exit_code_o !== 32'h0) begin nFails++; $display("[TB] FAIL mid_exit_code: got %h expected 0", exit_code_o); end
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'hF; bus.addr_i = '0; bus.wdata_i = '0;
    tgt_gnt_i = '0; tgt_rvalid_i = '0; tgt_rdata_i = '0;
    $display("[TB] starting lca_data_bus_router bench");
    test_reset();
    test_target_read();
    test_mmio_exit();
    test_print();
    test_decode_error();
    test_decode_map();
    test_outstanding();
    test_cycle_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
